// File: rtl/scie_fir_sequencer.sv
// scie_fir_sequencer: standalone upstream driver for the pipelined complex-FIR
// SCIE accelerator. It turns a coefficient stream and a complex sample stream
// (valid/ready) into LOAD / PUSH / gap / READ instruction sequences, and
// collects each result in a 2-entry first-word-fall-through output FIFO.
//
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   coef_*                  coefficient stream in (valid/ready, 32b re/im)
//   in_*                    sample stream in (valid/ready, 32b re/im)
//   out_*                   result stream out (valid/ready, FIFO head)
//   scie_valid/insn/rs1/rs2 instruction issue to the accelerator
//   scie_rd_real/imag       accelerator result
//   stat_* (optional)       samples accepted, results popped, stalled cycles
//
// Optional feature: define SCIE_SEQ_STATS_EN to add the stat_* counters.
module scie_fir_sequencer #(
  parameter int unsigned NTAPS      = 5,
  parameter int unsigned OP_LOAD    = 11,
  parameter int unsigned OP_PUSH    = 43,
  parameter int unsigned OP_READ    = 91,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        coef_valid,
  output logic        coef_ready,
  input  logic [31:0] coef_real,
  input  logic [31:0] coef_imag,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_real,
  input  logic [31:0] in_imag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_real,
  output logic [31:0] out_imag,
  output logic        scie_valid,
  output logic [31:0] scie_insn,
  output logic [31:0] scie_rs1_real,
  output logic [31:0] scie_rs1_imag,
  output logic [31:0] scie_rs2,
  input  logic [31:0] scie_rd_real,
  input  logic [31:0] scie_rd_imag
`ifdef SCIE_SEQ_STATS_EN
  ,
  output logic [31:0] stat_samples,
  output logic [31:0] stat_results,
  output logic [31:0] stat_stall
`endif
);

  localparam int unsigned TAP_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PUSH, S_GAP, S_READ, S_WAIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [TAP_W-1:0]   tap_idx;
  logic [31:0]        op_real;
  logic [31:0]        op_imag;

  logic [63:0]        fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         fifo_cnt;

  logic               coef_hs;
  logic               in_hs;
  logic               fifo_wr;
  logic               fifo_rd;

  // Handshakes are combinational off registered state; a coefficient wins over a sample.
  assign coef_ready = !reset && (state == S_IDLE) && coef_valid;
  assign in_ready   = !reset && (state == S_IDLE) && !coef_valid && (fifo_cnt < 2'd2);
  assign coef_hs    = coef_ready;
  assign in_hs      = in_valid && in_ready;

  // Operand registers drive rs1 directly.
  assign scie_rs1_real = op_real;
  assign scie_rs1_imag = op_imag;

  // Result capture happens on the last WAIT cycle; the IDLE count check guarantees a free slot.
  assign fifo_wr   = (state == S_WAIT) && (cyc_cnt == '0);
  assign fifo_rd   = out_valid && out_ready;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_real  = fifo_mem[rd_ptr][63:32];
  assign out_imag  = fifo_mem[rd_ptr][31:0];

  // Instruction sequencing FSM with registered issue outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      tap_idx    <= '0;
      op_real    <= '0;
      op_imag    <= '0;
      scie_valid <= 1'b0;
      scie_insn  <= '0;
      scie_rs2   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (coef_hs) begin
            op_real    <= coef_real;
            op_imag    <= coef_imag;
            scie_valid <= 1'b1;
            scie_insn  <= 32'(OP_LOAD);
            scie_rs2   <= 32'(tap_idx);
            state      <= S_LOAD;
          end else if (in_hs) begin
            op_real    <= in_real;
            op_imag    <= in_imag;
            scie_valid <= 1'b1;
            scie_insn  <= 32'(OP_PUSH);
            state      <= S_PUSH;
          end
        end
        S_LOAD: begin
          tap_idx    <= (tap_idx == TAP_W'(NTAPS - 1)) ? '0 : tap_idx + TAP_W'(1);
          scie_valid <= 1'b0;
          scie_insn  <= '0;
          scie_rs2   <= '0;
          state      <= S_IDLE;
        end
        S_PUSH: begin
          scie_valid <= 1'b0;
          scie_insn  <= '0;
          cyc_cnt    <= CNT_W'(GAP_CYCLES - 1);
          state      <= S_GAP;
        end
        S_GAP: begin
          if (cyc_cnt == '0) begin
            scie_valid <= 1'b1;
            scie_insn  <= 32'(OP_READ);
            state      <= S_READ;
          end else begin
            cyc_cnt <= cyc_cnt - CNT_W'(1);
          end
        end
        S_READ: begin
          scie_valid <= 1'b0;
          scie_insn  <= '0;
          cyc_cnt    <= CNT_W'(RD_LATENCY - 1);
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (cyc_cnt == '0) state <= S_IDLE;
          else               cyc_cnt <= cyc_cnt - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // 2-entry result FIFO; reset flushes it, including a result in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= {scie_rd_real, scie_rd_imag};
        wr_ptr           <= ~wr_ptr;
      end
      if (fifo_rd) rd_ptr <= ~rd_ptr;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef SCIE_SEQ_STATS_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_samples <= '0;
      stat_results <= '0;
      stat_stall   <= '0;
    end else begin
      if (in_hs)                 stat_samples <= stat_samples + 32'd1;
      if (fifo_rd)               stat_results <= stat_results + 32'd1;
      if (in_valid && !in_ready) stat_stall   <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scie_fir_sequencer.sv
// Directed testbench for scie_fir_sequencer with a behavioural model of the
// complex-FIR accelerator (sum of coef[k]*x[n-k], arithmetic shift right by 8).
module tb_scie_fir_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [31:0] coef_real = '0;
  logic [31:0] coef_imag = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_real = '0;
  logic [31:0] in_imag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_real;
  logic [31:0] out_imag;
  logic        scie_valid;
  logic [31:0] scie_insn;
  logic [31:0] scie_rs1_real;
  logic [31:0] scie_rs1_imag;
  logic [31:0] scie_rs2;
  logic [31:0] scie_rd_real = '0;
  logic [31:0] scie_rd_imag = '0;
`ifdef SCIE_SEQ_STATS_EN
  logic [31:0] stat_samples;
  logic [31:0] stat_results;
  logic [31:0] stat_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_samples = 0;
  int exp_results = 0;
  int exp_stall = 0;

  always #5 clock = ~clock;

  scie_fir_sequencer dut (
    .clock(clock), .reset(reset),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_real(coef_real), .coef_imag(coef_imag),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .scie_valid(scie_valid), .scie_insn(scie_insn),
    .scie_rs1_real(scie_rs1_real), .scie_rs1_imag(scie_rs1_imag),
    .scie_rs2(scie_rs2),
    .scie_rd_real(scie_rd_real), .scie_rd_imag(scie_rd_imag)
`ifdef SCIE_SEQ_STATS_EN
    ,
    .stat_samples(stat_samples), .stat_results(stat_results), .stat_stall(stat_stall)
`endif
  );

  // Accelerator model: its state survives the sequencer reset.
  longint acc_cr[5];
  longint acc_ci[5];
  longint acc_hr[5];
  longint acc_hi[5];

  initial begin
    for (int k = 0; k < 5; k++) begin
      acc_cr[k] = 0; acc_ci[k] = 0; acc_hr[k] = 0; acc_hi[k] = 0;
    end
  end

  always @(posedge clock) begin
    longint sr;
    longint si;
    if (scie_valid) begin
      if (scie_insn == 32'd11 && scie_rs2 < 32'd5) begin
        acc_cr[scie_rs2] = longint'($signed(scie_rs1_real));
        acc_ci[scie_rs2] = longint'($signed(scie_rs1_imag));
      end else if (scie_insn == 32'd43) begin
        for (int k = 4; k > 0; k--) begin
          acc_hr[k] = acc_hr[k-1];
          acc_hi[k] = acc_hi[k-1];
        end
        acc_hr[0] = longint'($signed(scie_rs1_real));
        acc_hi[0] = longint'($signed(scie_rs1_imag));
      end else if (scie_insn == 32'd91) begin
        sr = 0;
        si = 0;
        for (int k = 0; k < 5; k++) begin
          sr += acc_cr[k] * acc_hr[k] - acc_ci[k] * acc_hi[k];
          si += acc_cr[k] * acc_hi[k] + acc_ci[k] * acc_hr[k];
        end
        scie_rd_real <= 32'(sr >>> 8);
        scie_rd_imag <= 32'(si >>> 8);
      end
    end
  end

  // Expected statistics, tracked from the bench's view of the streams.
  always @(posedge clock) begin
    if (reset) begin
      exp_samples = 0; exp_results = 0; exp_stall = 0;
    end else begin
      if (in_valid && in_ready)   exp_samples++;
      if (out_valid && out_ready) exp_results++;
      if (in_valid && !in_ready)  exp_stall++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  // Offer a coefficient; returns one cycle after the handshake (LOAD visible).
  task automatic send_coef(input logic [31:0] r, input logic [31:0] i);
    int n;
    @(negedge clock);
    coef_real = r; coef_imag = i; coef_valid = 1'b1;
    #1;
    n = 0;
    while (!coef_ready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    check("coef_handshake", 32'(coef_ready), 1);
    @(posedge clock); #1;
    coef_valid = 1'b0;
  endtask

  // Offer a sample; returns one cycle after the handshake (PUSH visible).
  task automatic send_sample(input logic [31:0] r, input logic [31:0] i);
    int n;
    @(negedge clock);
    in_real = r; in_imag = i; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    check("in_handshake", 32'(in_ready), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; cyc counts cycles after the accept cycle.
  task automatic wait_out(input int start, output int cyc);
    cyc = start;
    while (!out_valid && cyc < start + 20) begin
      @(posedge clock); #1; cyc++;
    end
    check("out_valid_arrives", 32'(out_valid), 1);
  endtask

  logic [31:0] cr_tab [5];
  logic [31:0] ci_tab [5];
  int cyc;
  bit  seen;

  initial begin
    cr_tab[0] = 8636;   ci_tab[0] = 4720;
    cr_tab[1] = -8113;  ci_tab[1] = 7752;
    cr_tab[2] = -10134; ci_tab[2] = -11600;
    cr_tab[3] = 10743;  ci_tab[3] = 88;
    cr_tab[4] = 1182;   ci_tab[4] = 4549;

    // Reset values
    #2;
    check("rst_scie_valid", 32'(scie_valid), 0);
    check("rst_scie_insn", scie_insn, 0);
    check("rst_scie_rs2", scie_rs2, 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_coef_ready", 32'(coef_ready), 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // Coefficient loads: tap index 0..4
    for (int k = 0; k < 5; k++) begin
      send_coef(cr_tab[k], ci_tab[k]);
      check("load_valid", 32'(scie_valid), 1);
      check("load_insn", scie_insn, 11);
      check("load_rs2", scie_rs2, 32'(k));
      check("load_rs1_real", scie_rs1_real, cr_tab[k]);
      check("load_rs1_imag", scie_rs1_imag, ci_tab[k]);
    end

    // First sample: PUSH, gap, READ, result in cycle 5
    send_sample(1556, -10869);
    check("push_insn", scie_insn, 43);
    check("push_rs1_real", scie_rs1_real, 1556);
    check("push_rs2", scie_rs2, 0);
    @(posedge clock); #1;
    check("gap_valid", 32'(scie_valid), 0);
    check("gap_insn", scie_insn, 0);
    @(posedge clock); #1;
    check("read_valid", 32'(scie_valid), 1);
    check("read_insn", scie_insn, 91);
    wait_out(3, cyc);
    check("result_latency", 32'(cyc), 5);
    check("res0_real", out_real, 252887);
    check("res0_imag", out_imag, -337971);
    @(posedge clock); #1;
    check("res0_popped", 32'(out_valid), 0);

    // Second sample
    send_sample(6303, -3592);
    wait_out(1, cyc);
    check("res1_real", out_real, 558670);
    check("res1_imag", out_imag, 386609);
    @(posedge clock); #1;

    // Back-pressure: fill the FIFO, third sample must stall
    out_ready = 1'b0;
    send_sample(7010, 10767);
    wait_out(1, cyc);
    send_sample(8628, 12119);
    repeat (6) @(posedge clock);
    @(negedge clock);
    in_real = 1; in_imag = 2; in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #1;
      check("full_in_ready", 32'(in_ready), 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("bp_head_real", out_real, -607117);
    check("bp_head_imag", out_imag, 1156916);
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_second_valid", 32'(out_valid), 1);
    check("bp_second_real", out_real, -823818);
    check("bp_second_imag", out_imag, -160038);
    @(negedge clock);
    check("bp_drained", 32'(out_valid), 0);

    // Priority: coefficient wins over a simultaneous sample
    coef_real = 8636; coef_imag = 4720; coef_valid = 1'b1;
    in_real = 0; in_imag = 0; in_valid = 1'b1;
    #1;
    check("prio_coef_ready", 32'(coef_ready), 1);
    check("prio_in_ready", 32'(in_ready), 0);
    @(posedge clock); #1;
    coef_valid = 1'b0;
    check("prio_load_insn", scie_insn, 11);
    check("prio_tap_wrapped", scie_rs2, 0);
    check("prio_in_ready_load", 32'(in_ready), 0);
    cyc = 0;
    while (!in_ready && cyc < 10) begin
      @(negedge clock); #1; cyc++;
    end
    check("prio_in_ready_idle", 32'(in_ready), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("prio_push_insn", scie_insn, 43);
    wait_out(1, cyc);
    @(posedge clock); #1;

`ifdef SCIE_SEQ_STATS_EN
    check("stat_samples", stat_samples, 32'(exp_samples));
    check("stat_results", stat_results, 32'(exp_results));
    check("stat_stall", stat_stall, 32'(exp_stall));
`endif

    // Reset during GAP
    send_sample(1, 1);
    @(posedge clock); #1;
    check("pre_rst_gap_insn", scie_insn, 0);
    reset = 1'b1;
    #1;
    check("midrst_scie_valid", 32'(scie_valid), 0);
    check("midrst_scie_insn", scie_insn, 0);
    check("midrst_rs1_real", scie_rs1_real, 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
`ifdef SCIE_SEQ_STATS_EN
    check("midrst_stat_samples", stat_samples, 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid || scie_valid) seen = 1'b1;
    end
    check("post_rst_quiet", 32'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
